k005297_bubpos_tracker: RTL and testbench

- Downstream consumer of the supervisor's rotator outputs, inside the K005297 bubble memory controller.
- Counts bubble-loop positions: one position per full ROT20 revolution.
- Serves seek requests from the sequencer through a 4-phase handshake. Asserts a page-match window when the requested position rotates under the detector, and flags seek errors.

---
 rtl/k005297_bubpos_tracker.sv | 175 +++++++++++++++++
 tb/tb_k005297_bubpos_tracker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/k005297_bubpos_tracker.sv
// Bubble-loop position counter with a 4-phase seek handshake for the K005297
// controller: tracks the position under the detector and raises a page-match window.
module k005297_bubpos_tracker #(
  parameter int LOOP_LEN = 2053,
  parameter int PW       = 12
) (
  input  logic          i_MCLK,
  input  logic          i_MRST,
  input  logic          i_CLK2M_PCEN_n,
  input  logic [19:0]   i_ROT20_n,
  input  logic          i_SYS_RUN_FLAG,
  input  logic          i_SYS_RST_n,
  input  logic          i_SEEK_REQ,
  input  logic [PW-1:0] i_SEEK_POS,
  output logic          o_SEEK_ACK,
  output logic          o_SEEK_ERR,
  output logic [PW-1:0] o_POS,
  output logic          o_PAGE_MATCH,
  output logic          o_POS_TICK
);

  localparam int WW = PW + 1;
  localparam logic [PW-1:0] POS_LAST   = PW'(LOOP_LEN - 1);
  localparam logic [WW-1:0] LOOP_LEN_W = WW'(LOOP_LEN);
  localparam logic [WW-1:0] WD_LIMIT   = WW'(LOOP_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_MATCH = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [PW-1:0] pos_r, pos_s, pos_inc_s;
  logic [PW-1:0] target_r, target_s;
  logic [WW-1:0] wd_r, wd_s, wd_inc_s;
  logic          pos_tick_r;
  logic          match_r, match_s;
  logic          ack_r, ack_s;
  logic          err_r, err_s;
  logic          tick_s;

  // One position advance per ROT20 revolution, only while running and out of system reset.
  assign tick_s    = ~i_CLK2M_PCEN_n & ~i_ROT20_n[19] & i_SYS_RUN_FLAG & i_SYS_RST_n;
  assign pos_inc_s = (pos_r == POS_LAST) ? {PW{1'b0}} : pos_r + PW'(1);
  assign wd_inc_s  = wd_r + WW'(1);

  // Next position: system reset re-zeroes every cycle, otherwise advance on tick.
  always_comb begin
    pos_s = pos_r;
    if (!i_SYS_RST_n) begin
      pos_s = {PW{1'b0}};
    end else if (tick_s) begin
      pos_s = pos_inc_s;
    end else begin
      pos_s = pos_r;
    end
  end

  // Seek FSM next state and next registered outputs; the handshake itself runs
  // every MCLK so ack/accept latency is not stretched by the 2 MHz enable.
  always_comb begin
    state_s  = state_r;
    target_s = target_r;
    wd_s     = wd_r;
    match_s  = match_r;
    ack_s    = ack_r;
    err_s    = err_r;
    case (state_r)
      ST_IDLE: begin
        if (i_SEEK_REQ) begin
          target_s = i_SEEK_POS;
          wd_s     = {WW{1'b0}};
          if ({1'b0, i_SEEK_POS} >= LOOP_LEN_W) begin
            state_s = ST_ACK;
            ack_s   = 1'b1;
            err_s   = 1'b1;
          end else begin
            state_s = ST_SEEK;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEEK: begin
        if (!i_SEEK_REQ) begin
          state_s = ST_IDLE;
        end else if (!i_SYS_RST_n) begin
          state_s = ST_ACK;
          ack_s   = 1'b1;
          err_s   = 1'b1;
        end else if (tick_s) begin
          wd_s = wd_inc_s;
          // Compare the post-tick position so the window opens with o_POS==target.
          if (pos_inc_s == target_r) begin
            state_s = ST_MATCH;
            match_s = 1'b1;
          end else if (wd_inc_s >= WD_LIMIT) begin
            state_s = ST_ACK;
            ack_s   = 1'b1;
            err_s   = 1'b1;
          end else begin
            state_s = ST_SEEK;
          end
        end else begin
          state_s = ST_SEEK;
        end
      end
      ST_MATCH: begin
        if (!i_SEEK_REQ) begin
          state_s = ST_IDLE;
          match_s = 1'b0;
        end else if (!i_SYS_RST_n) begin
          state_s = ST_ACK;
          match_s = 1'b0;
          ack_s   = 1'b1;
          err_s   = 1'b1;
        end else if (tick_s) begin
          state_s = ST_ACK;
          match_s = 1'b0;
          ack_s   = 1'b1;
          err_s   = 1'b0;
        end else begin
          state_s = ST_MATCH;
        end
      end
      ST_ACK: begin
        if (!i_SEEK_REQ) begin
          state_s = ST_IDLE;
          ack_s   = 1'b0;
          err_s   = 1'b0;
        end else begin
          state_s = ST_ACK;
        end
      end
      default: begin
        state_s = ST_IDLE;
        match_s = 1'b0;
        ack_s   = 1'b0;
        err_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; master reset overrides everything.
  always_ff @(posedge i_MCLK) begin
    if (i_MRST) begin
      state_r    <= ST_IDLE;
      pos_r      <= {PW{1'b0}};
      target_r   <= {PW{1'b0}};
      wd_r       <= {WW{1'b0}};
      pos_tick_r <= 1'b0;
      match_r    <= 1'b0;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      pos_r      <= pos_s;
      target_r   <= target_s;
      wd_r       <= wd_s;
      pos_tick_r <= tick_s;
      match_r    <= match_s;
      ack_r      <= ack_s;
      err_r      <= err_s;
    end
  end

  assign o_POS        = pos_r;
  assign o_POS_TICK   = pos_tick_r;
  assign o_PAGE_MATCH = match_r;
  assign o_SEEK_ACK   = ack_r;
  assign o_SEEK_ERR   = err_r;

endmodule

// File: tb/tb_k005297_bubpos_tracker.sv
// Bench for k005297_bubpos_tracker (LOOP_LEN=8): directed seeks plus random seeks,
// checked against a modular-arithmetic position/seek model.
module tb_k005297_bubpos_tracker;

  localparam int L  = 8;
  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          mrst, pcen_n, run, sys_rst_n, req;
  logic [19:0]   rot;
  logic [PW-1:0] seek_pos, pos;
  logic          ack, err, match, pos_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int model_pos = 0;
  int rot_idx = 0;
  int ticks_left = -1;
  int ticks_seen = 0;
  bit exp_match = 1'b0;
  bit exp_ack = 1'b0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  k005297_bubpos_tracker #(.LOOP_LEN(L), .PW(PW)) dut (
    .i_MCLK(clk), .i_MRST(mrst), .i_CLK2M_PCEN_n(pcen_n), .i_ROT20_n(rot),
    .i_SYS_RUN_FLAG(run), .i_SYS_RST_n(sys_rst_n), .i_SEEK_REQ(req),
    .i_SEEK_POS(seek_pos), .o_SEEK_ACK(ack), .o_SEEK_ERR(err), .o_POS(pos),
    .o_PAGE_MATCH(match), .o_POS_TICK(pos_tick)
  );

  task automatic mclk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "/pos"}, 32'(pos), model_pos);
    chk({tag, "/match"}, 32'(match), 32'(exp_match));
    chk({tag, "/ack"}, 32'(ack), 32'(exp_ack));
    chk({tag, "/err"}, 32'(err), 32'(exp_err));
  endtask

  // One position advance: window closes into ack, or the countdown opens the window.
  task automatic model_tick();
    model_pos = (model_pos + 1) % L;
    if (exp_match) begin
      exp_match = 1'b0;
      exp_ack   = 1'b1;
      exp_err   = 1'b0;
    end else if (ticks_left > 0) begin
      ticks_left--;
      if (ticks_left == 0) begin
        exp_match  = 1'b1;
        ticks_left = -1;
      end
    end
  endtask

  // One PCEN enable cycle of the rotator followed by one idle MCLK (+ optional gap).
  task automatic pcen_step(input int gap);
    bit t;
    t = (rot_idx == 19) && run && sys_rst_n;
    pcen_n = 1'b0;
    rot = ~(20'd1 << rot_idx);
    mclk();
    pcen_n = 1'b1;
    if (t) model_tick();
    if (pos_tick === 1'b1) ticks_seen++;
    chk("pos_tick", 32'(pos_tick), 32'(t));
    check_outs("step");
    mclk();
    chk("pos_tick_lo", 32'(pos_tick), 32'd0);
    rot_idx = (rot_idx + 1) % 20;
    repeat (gap) mclk();
  endtask

  task automatic advance_to(input int p, input int gap);
    for (int i = 0; i < (L + 1) * 20 && model_pos != p; i++) pcen_step(gap);
    chk("advance_to", 32'(pos), p);
  endtask

  task automatic start_seek(input int t);
    req = 1'b1;
    seek_pos = PW'(t);
    mclk();
    if (t >= L) begin
      exp_ack = 1'b1;
      exp_err = 1'b1;
    end else begin
      ticks_left = ((t - model_pos + L - 1) % L) + 1;
    end
    check_outs("accept");
  endtask

  task automatic wait_ack(input string tag, input int gap);
    for (int i = 0; i < (L + 3) * 20 && !exp_ack; i++) pcen_step(gap);
    chk(tag, 32'(ack), 32'd1);
  endtask

  task automatic wait_match(input string tag);
    for (int i = 0; i < (L + 3) * 20 && !exp_match; i++) pcen_step(0);
    chk(tag, 32'(match), 32'd1);
  endtask

  task automatic end_seek();
    req = 1'b0;
    mclk();
    exp_match  = 1'b0;
    exp_ack    = 1'b0;
    exp_err    = 1'b0;
    ticks_left = -1;
    check_outs("drop");
  endtask

  initial begin
    mrst = 1'b1; pcen_n = 1'b1; run = 1'b1; sys_rst_n = 1'b1;
    req = 1'b0; seek_pos = '0; rot = '1;
    repeat (2) mclk();
    mrst = 1'b0;
    mclk();
    check_outs("reset");
    chk("reset/pos_tick", 32'(pos_tick), 32'd0);

    // Free run: 9 revolutions -> 0..7,0,1
    repeat (9 * 20) pcen_step(0);
    chk("tick_count", ticks_seen, 32'd9);
    chk("free_pos", 32'(pos), 32'd1);

    // Seek 5 from 2
    advance_to(2, 0);
    start_seek(5);
    wait_ack("seek5_ack", 0);
    chk("seek5_pos", 32'(pos), 32'd6);
    end_seek();

    // Seek to current position: full loop needed
    advance_to(3, 0);
    start_seek(3);
    wait_match("seek3_match");
    chk("seek3_pos", 32'(pos), 32'd3);
    wait_ack("seek3_ack", 0);
    end_seek();

    // Out-of-range target
    start_seek(9);
    chk("bad_pos", 32'(pos), 32'd4);
    end_seek();

    // Wrap to 0 from 6, then hold mid-window
    advance_to(6, 0);
    start_seek(0);
    wait_match("wrap_match");
    chk("wrap_pos", 32'(pos), 32'd0);
    run = 1'b0;
    repeat (25) pcen_step(0);
    run = 1'b1;
    wait_ack("wrap_ack", 0);
    end_seek();

    // System reset pulse during SEEK
    advance_to(2, 0);
    start_seek(6);
    repeat (5) pcen_step(0);
    sys_rst_n = 1'b0;
    mclk();
    sys_rst_n = 1'b1;
    model_pos = 0; exp_match = 1'b0; exp_ack = 1'b1; exp_err = 1'b1; ticks_left = -1;
    check_outs("sysrst");
    end_seek();

    // Master reset during MATCH
    advance_to(3, 0);
    start_seek(4);
    wait_match("mrst_match");
    mrst = 1'b1;
    req = 1'b0;
    mclk();
    model_pos = 0; exp_match = 1'b0; exp_ack = 1'b0; exp_err = 1'b0; ticks_left = -1;
    check_outs("mrst");
    chk("mrst/pos_tick", 32'(pos_tick), 32'd0);
    mrst = 1'b0;
    mclk();
    check_outs("post_mrst");

    // Random seeks with random lead-in and PCEN gaps
    for (int k = 0; k < 14; k++) begin
      int t;
      int g;
      t = int'($urandom_range(0, L + 2));
      g = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 30)) pcen_step(g);
      start_seek(t);
      wait_ack("rand_ack", g);
      end_seek();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
